// File: rtl/reg_dump_unit_pkg.sv
// Shared types and constants for the register dump unit.
package reg_dump_unit_pkg;

  localparam int unsigned REG_W   = 8;
  localparam int unsigned REG_D   = 4;
  localparam int unsigned ACC_IDX = 2 ** REG_D - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// Walks a (possibly wrapping) register index range and streams each value out
// over valid/ready, holding the register file while the snapshot is in flight.
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int unsigned W = REG_W,
  parameter int unsigned D = REG_D
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [D-1:0] first_addr,
  input  logic [D-1:0] last_addr,
  output logic [D-1:0] raddr_reg,
  input  logic [W-1:0] data_out_reg,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         rf_hold,
  output logic         done,
  output logic [W-1:0] checksum
);

  dump_state_t  state_q, state_d;
  logic [D-1:0] ptr_q, ptr_d;
  logic [D-1:0] last_q, last_d;
  logic [W-1:0] data_q, data_d;
  logic         last_flag_q, last_flag_d;
  logic [W-1:0] csum_q, csum_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Next-state and datapath; status flags are decoded from the next state so
  // they are registered yet line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    data_d      = data_q;
    last_flag_d = last_flag_q;
    csum_d      = csum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = first_addr;
          last_d  = last_addr;
          csum_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d      = data_out_reg;
        last_flag_d = (ptr_q == last_q);
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          csum_d = csum_q ^ data_q;
          if (last_flag_q) begin
            state_d = FIN;
          end else begin
            ptr_d   = ptr_q + D'(1);
            state_d = LOAD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      data_q      <= '0;
      last_flag_q <= 1'b0;
      csum_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      data_q      <= data_d;
      last_flag_q <= last_flag_d;
      csum_q      <= csum_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign raddr_reg = ptr_q;
  assign out_data  = data_q;
  assign out_last  = last_flag_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign rf_hold   = busy_q;
  assign done      = done_q;
  assign checksum  = csum_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Randomized bench for reg_dump_unit against a queue-based model of the dump
// range, the word stream and the running XOR.
module tb_reg_dump_unit;
  import reg_dump_unit_pkg::*;

  localparam int unsigned W      = REG_W;
  localparam int unsigned D      = REG_D;
  localparam int          N_REGS = 2 ** D;
  localparam int          BUDGET = 3000;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [D-1:0] first_addr, last_addr, raddr_reg;
  logic [W-1:0] data_out_reg, out_data, checksum;
  logic         out_valid, out_ready, out_last, busy, rf_hold, done;

  logic [W-1:0] rf [N_REGS];
  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  assign data_out_reg = rf[raddr_reg];

  reg_dump_unit #(.W(W), .D(D)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .raddr_reg(raddr_reg), .data_out_reg(data_out_reg),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .rf_hold(rf_hold), .done(done),
    .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One dump: drive start, play out_ready, score every accepted word.
  task automatic run_dump(input int f, input int l, input int ready_pct,
                          input bit inject, input int stall_word, input int stall_len);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_ck = '0;
    logic [W-1:0] prev_data = '0;
    bit           prev_stalled = 1'b0;
    int n, got, cyc, stalls;
    n = ((l - f + N_REGS) % N_REGS) + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rf[(f + i) % N_REGS]);
      exp_ck ^= rf[(f + i) % N_REGS];
    end
    got = 0;
    stalls = 0;
    @(negedge CLK);
    start = 1'b1;
    first_addr = D'(f);
    last_addr = D'(l);
    out_ready = 1'b1;
    @(negedge CLK);
    cyc = 1;
    while (cyc < BUDGET) begin
      start = inject && (cyc == 3 || cyc == 4);
      if (start) begin
        first_addr = D'($urandom);
        last_addr = D'($urandom);
      end
      if (done) break;
      chk("busy_hold", 32'({busy, rf_hold}), 32'b11);
      if (!out_valid)
        chk("raddr", 32'(raddr_reg), 32'((f + got) % N_REGS));
      if (out_valid && prev_stalled)
        chk("stall_stable", 32'(out_data), 32'(prev_data));
      if (out_valid && got == stall_word && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = ($urandom_range(99) < 32'(ready_pct));
      end
      if (out_valid && out_ready) begin
        if (got < n) begin
          chk("word", 32'(out_data), 32'(exp_q[got]));
          chk("last", 32'(out_last), 32'(got == n - 1));
        end
        got++;
      end
      prev_stalled = out_valid && !out_ready;
      prev_data = out_data;
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 32'(done), 32'd1);
    chk("word_count", 32'(got), 32'(n));
    chk("checksum", 32'(checksum), 32'(exp_ck));
    if (ready_pct == 100 && stall_len == 0)
      chk("latency", 32'(cyc), 32'(2 * n + 1));
    @(negedge CLK);
    chk("done_pulse", 32'({done, busy, rf_hold, out_valid}), 32'd0);
    chk("checksum_hold", 32'(checksum), 32'(exp_ck));
  endtask

  // Abort a four-word dump once its first word is on the port.
  task automatic reset_mid_send();
    int waited;
    @(negedge CLK);
    start = 1'b1;
    first_addr = 4'd0;
    last_addr = 4'd3;
    out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    chk("reach_send", 32'(out_valid), 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_outputs", 32'({out_valid, busy, rf_hold, done}), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post_rst_quiet", 32'({out_valid, busy, done}), 32'd0);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N_REGS; i++) rf[i] = W'(8'h10 + i);
    repeat (2) @(negedge CLK);
    chk("reset_flags", 32'({out_valid, out_last, busy, rf_hold, done}), 32'd0);
    chk("reset_data", 32'({out_data, checksum}), 32'd0);
    chk("reset_raddr", 32'(raddr_reg), 32'd0);
    RST_N = 1'b1;

    run_dump(2, 4, 100, 1'b0, -1, 0);
    run_dump(5, 5, 100, 1'b0, -1, 0);
    run_dump(14, 1, 100, 1'b0, -1, 0);
    run_dump(0, 2, 100, 1'b0, 1, 3);
    run_dump(3, 9, 100, 1'b1, -1, 0);
    run_dump(ACC_IDX, ACC_IDX, 100, 1'b0, -1, 0);
    run_dump(7, 6, 100, 1'b0, -1, 0);
    reset_mid_send();
    run_dump(1, 3, 100, 1'b0, -1, 0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N_REGS; i++) rf[i] = W'($urandom);
      run_dump(int'($urandom_range(N_REGS - 1)), int'($urandom_range(N_REGS - 1)),
               int'($urandom_range(100, 30)), bit'($urandom_range(1)), -1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
